// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pkg
//   Shared types for the branch resolve unit: FSM state encoding, 2-bit BHT
//   counter encoding and reset value, the captured jump-result record, and
//   the saturating counter update helper.
// ---------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2
  } br_state_e;

  // 2-bit bimodal counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bht_ctr_e;

  localparam logic [1:0] BHT_RESET_VAL = CTR_WNT;

  // Everything the resolve cycle needs, captured when the jump FU finishes.
  typedef struct packed {
    logic        is_cond;
    logic        cmp_res;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } jmp_rec_t;

  // Saturating move of a counter towards the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = BHT_RESET_VAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
//   Branch history table of 2**IDX_W two-bit saturating counters.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (all entries -> 01)
//     rd_idx          combinational read index
//     rd_taken        counter MSB at rd_idx (value before any same-cycle write)
//     wr_en           update strobe
//     wr_idx          entry to update
//     wr_taken        resolved direction; counter saturates at 00 / 11
// ---------------------------------------------------------------------------
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] ctr_q [ENTRIES];

  // NOTE: the whole array is reset, so it maps to flops rather than a RAM macro;
  // the predictor must restart from a known weakly-not-taken state after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_RESET_VAL;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

  // Async read sees the registered array, so a same-cycle write is not visible yet.
  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Consumes finished jump/branch results from the jump FU, resolves the
//   direction, checks the fetch-stage prediction, trains a 2-bit BHT and,
//   on a mispredict, pulses flush and holds a PC redirect until IF acks.
//
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     jmp_finish                   jump FU result valid (one-cycle pulse)
//     jmp_is_cond/cmp_res/pc/target  jump FU result fields
//     pred_taken, pred_target      prediction IF used for this instruction
//     if_pc, if_pred_taken         IF-side BHT lookup (combinational)
//     busy                         unit not idle; do not dispatch to jump FU
//     flush                        one-cycle squash on first redirect cycle
//     redirect_valid/pc/ack        redirect handshake to IF
//     stat_branches, stat_mispred  resolve / mispredict counters
//
//   Build option: define BR_STATS_EN to synthesize the statistics counters;
//   without it stat_branches and stat_mispred are tied to zero.
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_finish,
  input  logic        jmp_is_cond,
  input  logic        jmp_cmp_res,
  input  logic [31:0] jmp_pc,
  input  logic [31:0] jmp_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  br_state_e   state_q, state_d;
  jmp_rec_t    rec_q;
  logic        first_q;        // previous cycle was RESOLVE
  logic [31:0] redirect_pc_q;

  logic        taken;
  logic        mispred;
  logic [31:0] next_pc;

  // ---------------- resolve datapath ----------------
  always_comb begin
    taken   = ~rec_q.is_cond | rec_q.cmp_res;
    next_pc = taken ? rec_q.target : rec_q.pc + 32'd4;
    mispred = (taken != rec_q.pred_taken) | (next_pc != rec_q.pred_target);
  end

  // ---------------- FSM: state register ----------------
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (jmp_finish) state_d = ST_RESOLVE;
      ST_RESOLVE:  state_d = mispred ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: if (redirect_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy           = (state_q != ST_IDLE);
    redirect_valid = (state_q == ST_REDIRECT);
    flush          = (state_q == ST_REDIRECT) && first_q;
    redirect_pc    = redirect_pc_q;
  end

  // ---------------- capture / redirect registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q         <= '0;
      first_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      // Results arriving while busy are dropped: capture only from IDLE.
      if (state_q == ST_IDLE && jmp_finish) begin
        rec_q <= '{is_cond:     jmp_is_cond,
                   cmp_res:     jmp_cmp_res,
                   pc:          jmp_pc,
                   target:      jmp_target,
                   pred_taken:  pred_taken,
                   pred_target: pred_target};
      end
      first_q <= (state_q == ST_RESOLVE);
      if (state_q == ST_RESOLVE && mispred) redirect_pc_q <= next_pc;
    end
  end

  // ---------------- branch history table ----------------
  logic bht_wr_en;
  assign bht_wr_en = (state_q == ST_RESOLVE) && rec_q.is_cond;

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[BHT_IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (bht_wr_en),
    .wr_idx   (rec_q.pc[BHT_IDX_W+1:2]),
    .wr_taken (taken)
  );

  // Only the index bits of the IF lookup PC select a counter.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  // ---------------- statistics ----------------
`ifdef BR_STATS_EN
  logic [31:0] stat_branches_q, stat_mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else if (state_q == ST_RESOLVE) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispred) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int IDX_W = 6;
  localparam int N_ENT = 2 ** IDX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_finish, jmp_is_cond, jmp_cmp_res;
  logic [31:0] jmp_pc, jmp_target;
  logic        pred_taken;
  logic [31:0] pred_target, if_pc;
  logic        if_pred_taken, busy, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic [31:0] stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit #(.BHT_IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .jmp_finish     (jmp_finish),
    .jmp_is_cond    (jmp_is_cond),
    .jmp_cmp_res    (jmp_cmp_res),
    .jmp_pc         (jmp_pc),
    .jmp_target     (jmp_target),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .busy           (busy),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: counter value per BHT entry and expected statistics.
  int          bht_m [N_ENT];
  int unsigned st_br, st_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) bht_m[i] = 1;
    st_br  = 0;
    st_mis = 0;
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc);
    if_pc = pc;
    #1;
    check(tag, 32'(if_pred_taken), 32'(bht_m[idx_of(pc)] >= 2));
  endtask

  task automatic check_stats(input string tag);
`ifdef BR_STATS_EN
    check({tag, ".branches"}, stat_branches, st_br);
    check({tag, ".mispred"},  stat_mispred,  st_mis);
`else
    check({tag, ".branches"}, stat_branches, 32'd0);
    check({tag, ".mispred"},  stat_mispred,  32'd0);
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  32'(busy),           32'd0);
    check({tag, ".flush"}, 32'(flush),          32'd0);
    check({tag, ".rv"},    32'(redirect_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    step();
    check_idle(tag);
    check({tag, ".rpc"}, redirect_pc, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One complete transaction. ack_delay = number of REDIRECT cycles before
  // the ack cycle; rst_at >= 0 asserts rst on that REDIRECT cycle instead.
  task automatic run_branch(input string tag, input logic is_cond, input logic cmp,
                            input logic [31:0] pc, input logic [31:0] target,
                            input logic ptaken, input logic [31:0] ptarget,
                            input int ack_delay, input int rst_at);
    logic        tk, mis;
    logic [31:0] npc;
    int          idx;
    tk  = !is_cond || cmp;
    npc = tk ? target : pc + 32'd4;
    mis = (tk != ptaken) || (npc != ptarget);
    idx = idx_of(pc);

    jmp_is_cond = is_cond;
    jmp_cmp_res = cmp;
    jmp_pc      = pc;
    jmp_target  = target;
    pred_taken  = ptaken;
    pred_target = ptarget;
    jmp_finish  = 1'b1;
    step();
    jmp_finish  = 1'b0;

    // Resolve cycle: busy, nothing visible to IF yet, BHT still old.
    check({tag, ".res_busy"},  32'(busy),           32'd1);
    check({tag, ".res_flush"}, 32'(flush),          32'd0);
    check({tag, ".res_rv"},    32'(redirect_valid), 32'd0);
    check_pred({tag, ".pre_upd"}, pc);

    if (is_cond) begin
      if (tk) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
      else    bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
    end
    st_br++;
    if (mis) st_mis++;
    step();

    if (!mis) begin
      check_idle({tag, ".ok"});
      check_pred({tag, ".post_upd"}, pc);
      return;
    end

    for (int k = 0; k <= ack_delay; k++) begin
      check({tag, ".rd_rv"},    32'(redirect_valid), 32'd1);
      check({tag, ".rd_pc"},    redirect_pc,         npc);
      check({tag, ".rd_busy"},  32'(busy),           32'd1);
      check({tag, ".rd_flush"}, 32'(flush),          32'(k == 0));
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle({tag, ".rst"});
        check({tag, ".rst_rpc"}, redirect_pc, 32'd0);
        model_reset();
        return;
      end
      redirect_ack = (k == ack_delay);
      step();
      redirect_ack = 1'b0;
    end
    check_idle({tag, ".after_ack"});
    check_pred({tag, ".post_upd"}, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        is_c, cmp, tk, ptk;
    logic [31:0] pc, tgt, npc, ptg;

    rst          = 1'b1;
    jmp_finish   = 1'b0;
    jmp_is_cond  = 1'b0;
    jmp_cmp_res  = 1'b0;
    jmp_pc       = 32'd0;
    jmp_target   = 32'd0;
    pred_taken   = 1'b0;
    pred_target  = 32'd0;
    if_pc        = 32'd0;
    redirect_ack = 1'b0;
    model_reset();

    do_reset("reset");
    check_stats("reset_stats");
    check_pred("reset_bht", 32'h0000_0100);

    // Correctly predicted taken BEQ: no redirect, BHT[0] 01 -> 10.
    run_branch("beq_ok", 1, 1, 32'h100, 32'h140, 1, 32'h140, 0, -1);
    check_pred("beq_ok_idx0", 32'h0);

    // Same branch predicted not-taken: redirect to 0x140 held for 3 cycles.
    do_reset("rst2");
    run_branch("beq_mis", 1, 1, 32'h100, 32'h140, 0, 32'h104, 3, -1);

    // JALR with wrong target: redirect, BHT untouched.
    do_reset("rst3");
    run_branch("jalr", 0, 0, 32'h200, 32'h3F0, 1, 32'h204, 0, -1);
    check("jalr_bht0", 32'(if_pred_taken), 32'd0);

    // Four taken BEQ at 0x10: counter saturates at 11.
    do_reset("rst4");
    for (int i = 0; i < 4; i++) run_branch("sat_hi", 1, 1, 32'h10, 32'h80, 1, 32'h80, 0, -1);
    check_pred("sat_hi_final", 32'h10);
    // Three not-taken: 11 -> 10 -> 01 -> 00, then once more at 00.
    for (int i = 0; i < 4; i++) run_branch("sat_lo", 1, 0, 32'h10, 32'h80, 0, 32'h14, 0, -1);
    run_branch("from_00", 1, 1, 32'h10, 32'h80, 1, 32'h80, 1, -1);
    check_pred("from_00_final", 32'h10);

    // Not-taken at top of address space: pc+4 wraps to 0.
    run_branch("wrap", 1, 0, 32'hFFFF_FFFC, 32'h40, 0, 32'h0, 0, -1);

    // Statistics: 3 branches, 1 mispredicted.
    do_reset("rst5");
    run_branch("st_a", 1, 1, 32'h20, 32'h60, 1, 32'h60, 0, -1);
    run_branch("st_b", 0, 0, 32'h24, 32'h90, 1, 32'h90, 0, -1);
    run_branch("st_c", 1, 0, 32'h28, 32'h70, 1, 32'h70, 1, -1);
    check_stats("stats3");

    // Reset in the middle of a held redirect, then confirm counters restart at 01.
    run_branch("rst_mid", 1, 1, 32'h10, 32'h80, 1, 32'h84, 5, 2);
    check_stats("rst_mid_stats");
    for (int i = 0; i < N_ENT; i++) check_pred("rst_mid_bht", 32'(i * 4));
    run_branch("rst_mid_up", 1, 1, 32'h10, 32'h80, 1, 32'h80, 0, -1);

    // Randomized traffic over a small set of indices to exercise saturation.
    for (int t = 0; t < 300; t++) begin
      is_c = ($urandom_range(3) != 0);
      cmp  = 1'($urandom_range(1));
      pc   = {$urandom_range(255) == 0 ? 24'hFF_FFFF : 24'($urandom), 3'($urandom_range(7)), 5'b0} |
             {24'd0, 1'b0, 5'($urandom_range(31)) & 5'b00100, 2'b00};
      tgt  = {$urandom} & 32'hFFFF_FFFC;
      tk   = !is_c || cmp;
      npc  = tk ? tgt : pc + 32'd4;
      ptk  = ($urandom_range(4) == 0) ? !tk : tk;
      ptg  = ($urandom_range(4) == 0) ? ({$urandom} & 32'hFFFF_FFFC) : npc;
      run_branch("rand", is_c, cmp, pc, tgt, ptk, ptg, int'($urandom_range(3)), -1);
      for (int j = 0; j < int'($urandom_range(2)); j++) begin
        redirect_ack = 1'($urandom_range(1));
        step();
        redirect_ack = 1'b0;
        check_idle("rand_idle");
      end
      check_pred("rand_lookup", {$urandom});
    end
    check_stats("rand_stats");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
